// File: rtl/speed_test_sequencer.sv
// speed_test_sequencer: runs one ring-oscillator speed measurement and reads both counters back bytewise
module speed_test_sequencer #(
  parameter int TRIG_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int MAX_DIFF      = 3,
  parameter int MIN_COUNT     = 10
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [7:0]  dut_out,
  output logic        dut_nrst,
  output logic        dut_trig,
  output logic [2:0]  dut_sel,
  output logic [1:0]  dut_ring_en,
  output logic        busy,
  output logic        done,
  output logic [23:0] count0,
  output logic [23:0] count1,
  output logic [23:0] ticks0,
  output logic [23:0] ticks1,
  output logic [5:0]  err
);
  typedef enum logic [2:0] {IDLE, ARM, TRIG, SETTLE, CHECK, READ, EVAL, DONE} state_t;
  localparam logic [7:0]  TRIG_LAST   = 8'(TRIG_CYCLES - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [23:0] MIN_C       = 24'(MIN_COUNT);
  localparam logic [23:0] MAX_D       = 24'(MAX_DIFF);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  rd_q, rd_d;
  logic [47:0] cap_q;
  logic [23:0] ticks0_q, ticks1_q, diff;
  logic [5:0]  err_q;
  logic        dut_nrst_q, dut_trig_q, busy_q, done_q;
  logic [2:0]  dut_sel_q, idx_d, sel_d;
  logic [1:0]  dut_ring_en_q;
  // Next-state and phase counters; rd counts SET/CAP half-cycles of the six-byte readout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE:    state_d = start ? ARM : IDLE;
      ARM:     begin state_d = TRIG; cnt_d = '0; end
      TRIG:    begin
        state_d = cnt_q == TRIG_LAST ? SETTLE : TRIG;
        cnt_d   = cnt_q == TRIG_LAST ? 8'd0 : cnt_q + 8'd1;
      end
      SETTLE:  begin
        state_d = cnt_q == SETTLE_LAST ? CHECK : SETTLE;
        cnt_d   = cnt_q + 8'd1;
      end
      CHECK:   begin state_d = READ; rd_d = '0; end
      READ:    begin
        state_d = rd_q == 4'd11 ? EVAL : READ;
        rd_d    = rd_q + 4'd1;
      end
      EVAL:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    idx_d = rd_d[3:1];
    sel_d = idx_d < 3'd3 ? idx_d : idx_d + 3'd1;
    diff  = cap_q[23:0] >= cap_q[47:24] ? cap_q[23:0] - cap_q[47:24] : cap_q[47:24] - cap_q[23:0];
  end
  // State, registered macro controls decoded from the upcoming state, and result capture
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_q          <= '0;
      cap_q         <= '0;
      ticks0_q      <= '0;
      ticks1_q      <= '0;
      err_q         <= '0;
      dut_nrst_q    <= 1'b0;
      dut_trig_q    <= 1'b0;
      dut_sel_q     <= 3'b111;
      dut_ring_en_q <= 2'b00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      dut_nrst_q    <= state_d != IDLE;
      dut_trig_q    <= state_d == TRIG;
      dut_sel_q     <= state_d == READ ? sel_d : 3'b111;
      dut_ring_en_q <= state_d inside {ARM, TRIG, SETTLE, CHECK} ? 2'b11 : 2'b00;
      busy_q        <= state_d != IDLE;
      done_q        <= state_d == DONE;
      if (state_q == IDLE && start) begin
        cap_q    <= '0;
        ticks0_q <= '0;
        ticks1_q <= '0;
        err_q    <= '0;
      end
      if (state_q == ARM && dut_out[6]) err_q[5] <= 1'b1;
      if (state_q == CHECK && !dut_out[6]) err_q[4] <= 1'b1;
      if (state_q == READ && rd_q[0]) cap_q[{rd_q[3:1], 3'b000} +: 8] <= dut_out;
      if (state_q == EVAL) begin
        err_q[3:0] <= {cap_q[23:0] < MIN_C, cap_q[47:24] < MIN_C,
                       !cap_q[23] || !cap_q[47], diff > MAX_D};
        ticks0_q   <= ~cap_q[23:0];
        ticks1_q   <= ~cap_q[47:24];
      end
    end
  end
  assign dut_nrst    = dut_nrst_q;
  assign dut_trig    = dut_trig_q;
  assign dut_sel     = dut_sel_q;
  assign dut_ring_en = dut_ring_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign count0      = cap_q[23:0];
  assign count1      = cap_q[47:24];
  assign ticks0      = ticks0_q;
  assign ticks1      = ticks1_q;
  assign err         = err_q;
endmodule
